instruction_prefetch_unit: RTL and testbench

//  Fetch stage between the CPU core and the on-chip instruction ROM (1024 x 32 single-port

---
 rtl/instruction_prefetch_unit_if.sv | 34 +++
 rtl/instruction_prefetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_prefetch_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_prefetch_unit_if.sv
// Bus bundle for the instruction prefetch unit: the instruction-ROM read port
// and the valid/ready instruction stream towards decode.
// master = prefetch unit side, slave = ROM + decode side.
interface instruction_prefetch_unit_if #(
    parameter int ADDR_W = 10
);
    // ROM read port
    logic [ADDR_W-1:0] rom_address;
    logic              rom_chipselect;
    logic              rom_clken;
    logic              rom_write;
    logic [3:0]        rom_byteenable;
    logic [31:0]       rom_readdata;

    // Decode handshake
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr_data;
    logic [ADDR_W+1:0] instr_pc;

    modport master (
        output rom_address, rom_chipselect, rom_clken, rom_write, rom_byteenable,
        input  rom_readdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  rom_address, rom_chipselect, rom_clken, rom_write, rom_byteenable,
        output rom_readdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: walks a word PC, issues reads to a 1-cycle-latency
// instruction ROM, buffers returned words with their PC in a small FIFO and
// hands them to decode over valid/ready. A redirect pulse flushes everything
// and restarts fetching at the new target.
// Optional build macro PREFETCH_STATS_EN adds stat_fetch_cnt / stat_flush_cnt.
module instruction_prefetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [ADDR_W+1:0]   redirect_pc,
    instruction_prefetch_unit_if.master bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]         stat_fetch_cnt,
    output logic [15:0]         stat_flush_cnt
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] RESET_WORD = RESET_PC[ADDR_W+1:2];

    // Read pipeline: cs_reg/addr_reg is the read presented to the ROM this
    // cycle; ret_valid/ret_pc is the read whose data is on rom_readdata now.
    logic [ADDR_W-1:0] fetch_ptr;
    logic [ADDR_W-1:0] addr_reg;
    logic              cs_reg;
    logic              clken_reg;
    logic              ret_valid;
    logic [ADDR_W-1:0] ret_pc;

    // Prefetch FIFO
    logic [31:0]       mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] redirect_word;
    logic [OCC_W-1:0]  occupancy;
    logic              can_issue;
    logic              issue;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  out_idx;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Credit check counts both reads still in the ROM pipe, so the FIFO can never overflow
    always_comb begin
        redirect_word = redirect_pc[ADDR_W+1:2];
        occupancy     = {1'b0, count} + OCC_W'(cs_reg) + OCC_W'(ret_valid);
        can_issue     = fetch_en && (occupancy < OCC_W'(DEPTH));
        issue         = redirect_valid ? fetch_en : can_issue;
        push          = ret_valid && !redirect_valid;
        pop           = (count != '0) && bus.instr_ready && !redirect_valid;
        // When empty, show the most recently written slot so outputs hold still
        out_idx       = (count == '0) ? rd_ptr - PTR_W'(1) : rd_ptr;
    end

    // Fetch pointer, ROM strobe pipeline and FIFO bookkeeping; redirect overrides all
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_ptr <= RESET_WORD;
            addr_reg  <= '0;
            cs_reg    <= 1'b0;
            clken_reg <= 1'b0;
            ret_valid <= 1'b0;
            ret_pc    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            clken_reg <= 1'b1;
            // A read presented during a redirect belongs to the old stream: drop it
            ret_valid <= cs_reg && !redirect_valid;
            ret_pc    <= addr_reg;
            cs_reg    <= issue;
            if (redirect_valid) begin
                // Target is fetched straight away so its word reaches decode 3 cycles later
                addr_reg  <= redirect_word;
                fetch_ptr <= fetch_en ? redirect_word + ADDR_W'(1) : redirect_word;
                rd_ptr    <= wr_ptr;
                count     <= '0;
            end else begin
                if (can_issue) begin
                    addr_reg  <= fetch_ptr;
                    fetch_ptr <= fetch_ptr + ADDR_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage, one register slot per entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Capture the returning ROM word and its PC into the slot being written
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_data[gi] <= '0;
                    mem_pc[gi]   <= '0;
                end else if (push && (wr_ptr == PTR_W'(gi))) begin
                    mem_data[gi] <= bus.rom_readdata;
                    mem_pc[gi]   <= ret_pc;
                end
            end
        end
    endgenerate

    assign bus.rom_address    = addr_reg;
    assign bus.rom_chipselect = cs_reg;
    assign bus.rom_clken      = clken_reg;
    assign bus.rom_write      = 1'b0;
    assign bus.rom_byteenable = 4'hF;
    assign bus.instr_valid    = (count != '0);
    assign bus.instr_data     = mem_data[out_idx];
    assign bus.instr_pc       = {mem_pc[out_idx], 2'b00};

`ifdef PREFETCH_STATS_EN
    // Wrapping event counters: issued ROM reads and redirect flushes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_fetch_cnt <= '0;
            stat_flush_cnt <= '0;
        end else begin
            if (issue) begin
                stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                stat_flush_cnt <= stat_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Self-checking bench for instruction_prefetch_unit: ROM model, scoreboard of
// expected fetch stream (restarted on each redirect/reset), directed timing
// checks and a randomized phase. Honours PREFETCH_STATS_EN when defined.
module tb_instruction_prefetch_unit;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              fetch_en;
    logic              redirect_valid;
    logic [ADDR_W+1:0] redirect_pc;
`ifdef PREFETCH_STATS_EN
    logic [31:0]       stat_fetch_cnt;
    logic [15:0]       stat_flush_cnt;
    int                tb_fetch_cnt = 0;
    int                tb_flush_cnt = 0;
`endif

    instruction_prefetch_unit_if #(.ADDR_W(ADDR_W)) bus();

    instruction_prefetch_unit #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bus           (bus)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_fetch_cnt(stat_fetch_cnt),
        .stat_flush_cnt(stat_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;
    int popped = 0;

    logic [31:0]       rom [1024];
    logic [ADDR_W-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: after a (re)start at a byte target, decode must see the
    // consecutive word addresses from there, modulo ROM size, with ROM contents.
    task automatic start_stream(input logic [ADDR_W+1:0] target);
        logic [ADDR_W-1:0] w;
        exp_q.delete();
        w = target[ADDR_W+1:2];
        for (int k = 0; k < 1024; k++) begin
            exp_q.push_back(w);
            w = w + 1'b1;
        end
    endtask

    task automatic do_redirect(input logic [ADDR_W+1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        start_stream(target);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    // ROM model: registered address, data one cycle after chipselect
    always @(posedge clk) begin
        if (bus.rom_chipselect && bus.rom_clken)
            bus.rom_readdata <= rom[bus.rom_address];
    end

    // Monitor: every accepted word is compared with the scoreboard head
    always @(negedge clk) begin
        logic [ADDR_W-1:0] idx;
        if (reset_n && bus.instr_valid && bus.instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_word: got pc %h expected no word", bus.instr_pc);
            end else begin
                idx = exp_q.pop_front();
                $display("[TB] accept pc=%03h data=%08h", bus.instr_pc, bus.instr_data);
                check("instr_pc", 32'(bus.instr_pc), 32'({idx, 2'b00}));
                check("instr_data", bus.instr_data, rom[idx]);
                popped++;
            end
        end
    end

`ifdef PREFETCH_STATS_EN
    // Event tallies for the statistics outputs
    always @(negedge clk) begin
        if (!reset_n) tb_fetch_cnt = 0;
        else if (bus.rom_chipselect) tb_fetch_cnt++;
    end
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_flush_cnt = 0;
        else if (redirect_valid) tb_flush_cnt++;
    end
`endif

    initial begin
        int base;
        int n;
        reset_n         = 1'b0;
        fetch_en        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_cs", 32'(bus.rom_chipselect), 32'd0);
        check("rst_clken", 32'(bus.rom_clken), 32'd0);
        check("rst_addr", 32'(bus.rom_address), 32'd0);
        check("rst_write", 32'(bus.rom_write), 32'd0);
        check("rst_be", 32'(bus.rom_byteenable), 32'hF);
        check("rst_data", bus.instr_data, 32'd0);
        check("rst_pc", 32'(bus.instr_pc), 32'd0);

        // T1: reset release, streaming at one word per cycle
        fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        start_stream('0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("t1_cs", 32'(bus.rom_chipselect), 32'd1);
        check("t1_addr", 32'(bus.rom_address), 32'd0);
        check("t1_clken", 32'(bus.rom_clken), 32'd1);
        check("t1_valid_c1", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_c2", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_c3", 32'(bus.instr_valid), 32'd1);
        check("t1_first_pc", 32'(bus.instr_pc), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("t1_back_to_back", 32'(bus.rom_chipselect), 32'd1);
            @(posedge clk); #1;
        end

        // T2: decode stalled -> exactly 4 reads, then words 0..3 in order
        bus.instr_ready = 1'b0;
        do_redirect(12'h000);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rom_chipselect) n++;
            @(posedge clk); #1;
        end
        check("t2_issued", 32'(n), 32'd4);
        check("t2_valid", 32'(bus.instr_valid), 32'd1);
        check("t2_head_pc", 32'(bus.instr_pc), 32'h0);
        fetch_en = 1'b0;
        base = popped;
        bus.instr_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t2_drained", 32'(popped - base), 32'd4);
        check("t2_empty", 32'(bus.instr_valid), 32'd0);
        check("t2_no_issue", 32'(bus.rom_chipselect), 32'd0);

        // T3: redirect while full with a read in flight
        fetch_en = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_redirect(12'h100);
        check("t3_flush_r1", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        check("t3_flush_r2", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        check("t3_valid_r3", 32'(bus.instr_valid), 32'd1);
        check("t3_pc", 32'(bus.instr_pc), 32'h100);
        check("t3_data", bus.instr_data, rom[10'h40]);
        bus.instr_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // T4: wrap at the top of the ROM
        base = popped;
        do_redirect(12'hFFC);
        repeat (10) @(posedge clk);
        #1;
        check("t4_wrap_pops", 32'(popped - base >= 3), 32'd1);

        // T5: redirect with simultaneous pop, then back-to-back redirects
        do_redirect(12'h020);
        do_redirect(12'h040);
        base = popped;
        repeat (10) @(posedge clk);
        #1;
        check("t5_pops", 32'(popped - base > 0), 32'd1);

        // T6: asynchronous reset mid-stream
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("t6_valid_async", 32'(bus.instr_valid), 32'd0);
        check("t6_cs_async", 32'(bus.rom_chipselect), 32'd0);
`ifdef PREFETCH_STATS_EN
        check("t6_stat_fetch_rst", stat_fetch_cnt, 32'd0);
        check("t6_stat_flush_rst", 32'(stat_flush_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        start_stream('0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6_valid_c2", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        check("t6_valid_c3", 32'(bus.instr_valid), 32'd1);
        check("t6_restart_pc", 32'(bus.instr_pc), 32'd0);
        do_redirect(12'h200);
        repeat (5) @(posedge clk);
        #1;
        do_redirect(12'h300);
        repeat (5) @(posedge clk);
        #1;
`ifdef PREFETCH_STATS_EN
        check("t6_stat_fetch", stat_fetch_cnt, 32'(tb_fetch_cnt));
        check("t6_stat_flush", 32'(stat_flush_cnt), 32'(tb_flush_cnt));
`endif

        // Randomized phase
        for (int c = 0; c < 1500; c++) begin
            fetch_en        = ($urandom % 8) != 0;
            bus.instr_ready = ($urandom % 3) != 0;
            if ($urandom % 40 == 0)
                do_redirect(12'($urandom));
            else begin
                @(posedge clk); #1;
            end
        end
        fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("final_write", 32'(bus.rom_write), 32'd0);
        check("final_be", 32'(bus.rom_byteenable), 32'hF);
`ifdef PREFETCH_STATS_EN
        check("final_stat_fetch", stat_fetch_cnt, 32'(tb_fetch_cnt));
        check("final_stat_flush", 32'(stat_flush_cnt), 32'(tb_flush_cnt));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
